// File: rtl/nem_ohmux_sel_seq.sv
// nem_ohmux_sel_seq: sequencer for a relay-based 2:1 one-hot mux.
// Drives the S0/S1 relay selects with break-before-make, waits for the
// relay to pull in, then samples the inverted mux outputs ZN into DOUT.
module nem_ohmux_sel_seq #(
    parameter int DEAD_CYC   = 4,  // break-before-make cycles, 1..255
    parameter int SETTLE_CYC = 8   // relay pull-in cycles, 1..255
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       REQ_VLD,
    output logic       REQ_RDY,
    input  logic [1:0] REQ_SEL,
    output logic       S0,
    output logic       S1,
    input  logic [7:0] ZN,
    output logic [7:0] DOUT,
    output logic       DOUT_VLD,
    input  logic       DOUT_RDY,
    output logic       ERR
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BREAK  = 3'd1,
        MAKE   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_I0  = 2'd0;
    localparam logic [1:0] SEL_I1  = 2'd1;
    localparam logic [1:0] SEL_REL = 2'd2;
    localparam logic [1:0] SEL_BAD = 2'd3;

    // Counters are loaded with N-1 so that a state lasts exactly N cycles
    // while the counter steps down to 0.
    localparam logic [7:0] DEAD_LD   = 8'(DEAD_CYC - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] dead_q, dead_d;
    logic [7:0] settle_q, settle_d;
    logic [1:0] tgt_q, tgt_d;      // pending request code
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic [7:0] dout_q, dout_d;
    logic       dvld_q, dvld_d;
    logic       err_q, err_d;
    logic       accept;
    logic       tgt_is_on;

    assign REQ_RDY  = (state_q == IDLE);
    assign accept   = REQ_VLD && REQ_RDY;
    assign S0       = s0_q;
    assign S1       = s1_q;
    assign DOUT     = dout_q;
    assign DOUT_VLD = dvld_q;
    assign ERR      = err_q;

    // Requested path already closed: skip the break and sample directly.
    assign tgt_is_on = ((REQ_SEL == SEL_I0) && s0_q) ||
                       ((REQ_SEL == SEL_I1) && s1_q);

    // State register; reset drops both relays and discards pending work.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: selects, counters, captured data, error pulse.
    always_ff @(posedge CP) begin
        if (RST) begin
            dead_q   <= 8'd0;
            settle_q <= 8'd0;
            tgt_q    <= SEL_I0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            dout_q   <= 8'h00;
            dvld_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dead_q   <= dead_d;
            settle_q <= settle_d;
            tgt_q    <= tgt_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            dout_q   <= dout_d;
            dvld_q   <= dvld_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-output logic; selects only ever change from
    // IDLE (both off) or at the end of BREAK (only the target on), which
    // keeps the two relays from ever overlapping.
    always_comb begin
        state_d  = state_q;
        dead_d   = dead_q;
        settle_d = settle_q;
        tgt_d    = tgt_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        dout_d   = dout_q;
        dvld_d   = dvld_q;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (REQ_SEL == SEL_BAD) begin
                        err_d = 1'b1;
                    end else if (tgt_is_on) begin
                        tgt_d   = REQ_SEL;
                        state_d = SAMPLE;
                    end else begin
                        // Release, or a path that is not yet closed.
                        tgt_d   = REQ_SEL;
                        s0_d    = 1'b0;
                        s1_d    = 1'b0;
                        dead_d  = DEAD_LD;
                        state_d = BREAK;
                    end
                end
            end

            BREAK: begin
                if (dead_q == 8'd0) begin
                    if (tgt_q == SEL_REL) begin
                        state_d = IDLE;
                    end else begin
                        s0_d     = (tgt_q == SEL_I0);
                        s1_d     = (tgt_q == SEL_I1);
                        settle_d = SETTLE_LD;
                        state_d  = MAKE;
                    end
                end else begin
                    dead_d = dead_q - 8'd1;
                end
            end

            MAKE: begin
                if (settle_q == 8'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end

            SAMPLE: begin
                // The mux drives inverted data; restore polarity here.
                dout_d  = ~ZN;
                dvld_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                if (DOUT_RDY) begin
                    dvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Directed bench for nem_ohmux_sel_seq (DEAD_CYC=4, SETTLE_CYC=8).
// Cycle t+k is the period following the k-th edge after the accept edge.
module tb_nem_ohmux_sel_seq;

    logic       CP = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VLD = 1'b0;
    logic       REQ_RDY;
    logic [1:0] REQ_SEL = 2'd0;
    logic       S0, S1;
    logic [7:0] ZN = 8'h00;
    logic [7:0] DOUT;
    logic       DOUT_VLD;
    logic       DOUT_RDY = 1'b0;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    nem_ohmux_sel_seq #(.DEAD_CYC(4), .SETTLE_CYC(8)) dut (
        .CP(CP), .RST(RST), .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY),
        .REQ_SEL(REQ_SEL), .S0(S0), .S1(S1), .ZN(ZN), .DOUT(DOUT),
        .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY), .ERR(ERR)
    );

    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, vld;
        logic [1:0] sel;
        logic [7:0] zn;
        logic       drdy;
        logic       e_s0, e_s1;
        logic [7:0] e_dout;
        logic       e_dvld, e_rdy, e_err;
    } vec_t;

    function automatic vec_t mk(logic rst, logic vld, logic [1:0] sel,
                                logic [7:0] zn, logic drdy, logic s0, logic s1,
                                logic [7:0] dout, logic dvld, logic rdy, logic err);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = sel; v.zn = zn; v.drdy = drdy;
        v.e_s0 = s0; v.e_s1 = s1; v.e_dout = dout;
        v.e_dvld = dvld; v.e_rdy = rdy; v.e_err = err;
        return v;
    endfunction

    task automatic tick;
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    vec_t tbl [10];
    int   gap;

    initial begin
        // rst vld sel zn drdy | s0 s1 dout dvld rdy err
        tbl[0] = mk(1, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0); // reset
        tbl[1] = mk(1, 1, 2'd3, 8'h12, 0, 0, 0, 8'h00, 0, 1, 0); // reset beats request
        tbl[2] = mk(0, 1, 2'd3, 8'h34, 0, 0, 0, 8'h00, 0, 1, 1); // illegal -> ERR
        tbl[3] = mk(0, 0, 2'd0, 8'h34, 0, 0, 0, 8'h00, 0, 1, 0); // ERR one cycle
        tbl[4] = mk(0, 1, 2'd2, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0); // release, nothing on: t+1
        tbl[5] = mk(0, 1, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0); // t+2, request ignored
        tbl[6] = mk(0, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0); // t+3
        tbl[7] = mk(0, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0); // t+4
        tbl[8] = mk(0, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0); // t+5 back to IDLE
        tbl[9] = mk(0, 0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0); // ignored request not queued

        for (int i = 0; i < 10; i++) begin
            RST = tbl[i].rst; REQ_VLD = tbl[i].vld; REQ_SEL = tbl[i].sel;
            ZN = tbl[i].zn; DOUT_RDY = tbl[i].drdy;
            tick;
            chk($sformatf("vec%0d_s0", i), S0, tbl[i].e_s0);
            chk($sformatf("vec%0d_s1", i), S1, tbl[i].e_s1);
            chk($sformatf("vec%0d_dout", i), DOUT, tbl[i].e_dout);
            chk($sformatf("vec%0d_dvld", i), DOUT_VLD, tbl[i].e_dvld);
            chk($sformatf("vec%0d_rdy", i), REQ_RDY, tbl[i].e_rdy);
            chk($sformatf("vec%0d_err", i), ERR, tbl[i].e_err);
        end
        RST = 0; REQ_VLD = 0; DOUT_RDY = 0;

        // Full path to I0 with ZN=A5
        REQ_VLD = 1; REQ_SEL = 2'd0; ZN = 8'hA5;
        tick;
        REQ_VLD = 0;
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("full_s0_t%0d", k), S0, (k >= 5));
            chk($sformatf("full_s1_t%0d", k), S1, 0);
            chk($sformatf("full_dvld_t%0d", k), DOUT_VLD, (k == 14));
            if (k < 14) tick;
        end
        chk("full_dout", DOUT, 8'h5A);

        // Consumer stalls for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("hold_dvld", DOUT_VLD, 1);
            chk("hold_dout", DOUT, 8'h5A);
            chk("hold_rdy", REQ_RDY, 0);
        end
        DOUT_RDY = 1;
        tick;
        DOUT_RDY = 0;
        chk("hold_rel_dvld", DOUT_VLD, 0);
        chk("hold_rel_rdy", REQ_RDY, 1);
        chk("hold_keep_s0", S0, 1);

        // Switch I0 -> I1 with break-before-make
        chk("sw_pre_s0", S0, 1);
        REQ_VLD = 1; REQ_SEL = 2'd1; ZN = 8'h3C;
        tick;
        REQ_VLD = 0;
        gap = 0;
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("sw_overlap_t%0d", k), S0 & S1, 0);
            chk($sformatf("sw_s0_t%0d", k), S0, 0);
            chk($sformatf("sw_s1_t%0d", k), S1, (k >= 5));
            chk($sformatf("sw_dvld_t%0d", k), DOUT_VLD, (k == 14));
            if (!S0 && !S1) gap++;
            if (k < 14) tick;
        end
        chk("sw_gap", gap, 4);
        chk("sw_dout", DOUT, 8'hC3);
        DOUT_RDY = 1;
        tick;
        DOUT_RDY = 0;

        // Fast path on already-connected I1
        REQ_VLD = 1; REQ_SEL = 2'd1; ZN = 8'hFF;
        tick;
        REQ_VLD = 0;
        chk("fast_t1_s1", S1, 1);
        chk("fast_t1_s0", S0, 0);
        chk("fast_t1_dvld", DOUT_VLD, 0);
        chk("fast_t1_rdy", REQ_RDY, 0);
        tick;
        chk("fast_t2_dvld", DOUT_VLD, 1);
        chk("fast_t2_dout", DOUT, 8'h00);
        chk("fast_t2_s1", S1, 1);
        DOUT_RDY = 1;
        tick;
        DOUT_RDY = 0;
        chk("fast_idle_rdy", REQ_RDY, 1);

        // Illegal select with I1 connected
        REQ_VLD = 1; REQ_SEL = 2'd3;
        tick;
        REQ_VLD = 0;
        chk("err_pulse", ERR, 1);
        chk("err_s1", S1, 1);
        chk("err_s0", S0, 0);
        chk("err_rdy", REQ_RDY, 1);
        tick;
        chk("err_clear", ERR, 0);
        chk("err_s1_keep", S1, 1);

        // Reset during MAKE cycle 3 (t+7)
        REQ_VLD = 1; REQ_SEL = 2'd0; ZN = 8'h11;
        tick;
        REQ_VLD = 0;
        for (int i = 0; i < 6; i++) tick;
        chk("rst_mk_s0", S0, 1);
        chk("rst_mk_s1", S1, 0);
        RST = 1;
        tick;
        RST = 0;
        chk("rst_s0", S0, 0);
        chk("rst_s1", S1, 0);
        chk("rst_dvld", DOUT_VLD, 0);
        chk("rst_rdy", REQ_RDY, 1);
        chk("rst_dout", DOUT, 8'h00);
        chk("rst_err", ERR, 0);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("rst_discard_dvld", DOUT_VLD, 0);
            chk("rst_discard_s0", S0, 0);
        end

        // Release with I0 connected
        REQ_VLD = 1; REQ_SEL = 2'd0; ZN = 8'h0F;
        tick;
        REQ_VLD = 0;
        for (int i = 0; i < 30 && !DOUT_VLD; i++) tick;
        chk("rel_conn_dvld", DOUT_VLD, 1);
        chk("rel_conn_dout", DOUT, 8'hF0);
        DOUT_RDY = 1;
        tick;
        DOUT_RDY = 0;
        chk("rel_conn_s0", S0, 1);
        REQ_VLD = 1; REQ_SEL = 2'd2;
        tick;
        REQ_VLD = 0;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("rel_s0_t%0d", k), S0, 0);
            chk($sformatf("rel_s1_t%0d", k), S1, 0);
            chk($sformatf("rel_dvld_t%0d", k), DOUT_VLD, 0);
            chk($sformatf("rel_rdy_t%0d", k), REQ_RDY, (k >= 5));
            if (k < 7) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nem_ohmux_sel_seq.md
NEM_OHMUX_SEL_SEQ -- requirements
Module: nem_ohmux_sel_seq

Interface
REQ-001 SHALL have parameter DEAD_CYC, default 4: break-before-make cycles with S0=S1=0; legal range 1..255.
REQ-002 SHALL have parameter SETTLE_CYC, default 8: relay pull-in cycles before sampling; legal range 1..255.
REQ-003 SHALL have port CP, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port REQ_VLD, input, 1 bit: request valid.
REQ-006 SHALL have port REQ_RDY, output, 1 bit: request ready; a request is accepted on any edge with REQ_VLD=1 and REQ_RDY=1.
REQ-007 SHALL have port REQ_SEL, input, 2 bits: 0=connect I0, 1=connect I1, 2=release, 3=illegal.
REQ-008 SHALL have port S0, output, 1 bit: one-hot relay select for mux input I0, registered.
REQ-009 SHALL have port S1, output, 1 bit: one-hot relay select for mux input I1, registered.
REQ-010 SHALL have port ZN, input, 8 bits: inverted mux outputs ZN_0..ZN_7, bit i = ZN_i.
REQ-011 SHALL have port DOUT, output, 8 bits: captured data, re-inverted (DOUT = ~ZN).
REQ-012 SHALL have port DOUT_VLD, output, 1 bit: DOUT valid.
REQ-013 SHALL have port DOUT_RDY, input, 1 bit: consumer ready; a result is consumed on any edge with DOUT_VLD=1 and DOUT_RDY=1.
REQ-014 SHALL have port ERR, output, 1 bit: one-cycle pulse on acceptance of REQ_SEL=3.

Function
REQ-015 SHALL implement the states IDLE, BREAK, MAKE, SAMPLE and DONE, and SHALL drive REQ_RDY=1 only in IDLE.
REQ-016 SHALL never drive S0=1 and S1=1 in the same cycle.
REQ-017 SHALL place at least DEAD_CYC consecutive cycles with S0=S1=0 between any deassertion of one select and any assertion of the other select.
REQ-018 On acceptance in IDLE of REQ_SEL 0 or 1 when the target select is already 1, SHALL go to SAMPLE (fast path), leave the selects unchanged and not break.
REQ-019 On any other acceptance in IDLE of REQ_SEL 0, 1 or 2, SHALL go to BREAK, drive S0=S1=0 from the next cycle, and remain in BREAK for exactly DEAD_CYC cycles.
REQ-020 BREAK SHALL exit to IDLE if the request was 2 (release; no DOUT_VLD), and SHALL otherwise exit to MAKE.
REQ-021 MAKE SHALL assert only the target select and last exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-022 SAMPLE SHALL last one cycle, at whose closing edge it SHALL capture DOUT = ~ZN, set DOUT_VLD=1 and go to DONE.
REQ-023 DONE SHALL hold DOUT and DOUT_VLD stable until DOUT_RDY=1, then clear DOUT_VLD and return to IDLE on that same edge.
REQ-024 Latency from the accept edge t: the full path SHALL give the break at cycle t+1, select asserted at t+DEAD_CYC+1 and DOUT_VLD at t+DEAD_CYC+SETTLE_CYC+2; the fast path SHALL give DOUT_VLD at t+2.
REQ-025 The connected select SHALL remain asserted through IDLE and DONE until a release request or a request for the other path.
REQ-026 Acceptance of REQ_SEL=3 SHALL pulse ERR high for the next cycle, keep the FSM in IDLE and leave S0/S1 unchanged.
REQ-027 A release request while nothing is connected SHALL still perform the full DEAD_CYC BREAK, then go to IDLE.
REQ-028 The DEAD_CYC and SETTLE_CYC counters SHALL be 8 bits wide, down-count to 0, never wrap, and be reloaded on entry to their state.
REQ-029 REQ_VLD outside IDLE SHALL be ignored and SHALL not be queued.

Reset
REQ-030 When RST=1 at an edge, the next cycle SHALL have state=IDLE, S0=0, S1=0, DOUT=8'h00, DOUT_VLD=0, ERR=0, REQ_RDY=1 and counters=0.
REQ-031 RST SHALL take priority over every other input, and an RST in any state (including mid-MAKE) SHALL drop both selects at that edge and discard the pending request and DOUT.

Verification
REQ-032 Bench SHALL cover: after reset, request SEL=0 with ZN=8'hA5 and DEAD=4, SETTLE=8 -> S0=0 for cycles t+1..t+4, S0=1 from t+5, DOUT_VLD at t+14, DOUT=8'h5A.
REQ-033 Bench SHALL cover: with I0 connected, request SEL=1 -> S0 falls at t+1, S1 rises at t+5, no overlap cycle, and the S0=S1=0 gap is exactly 4 cycles.
REQ-034 Bench SHALL cover: with I1 connected, request SEL=1 with ZN=8'hFF -> no break, DOUT_VLD at t+2, DOUT=8'h00.
REQ-035 Bench SHALL cover: DOUT_RDY held 0 for 10 cycles -> DOUT and DOUT_VLD stable and REQ_RDY=0 throughout, then IDLE one cycle after DOUT_RDY=1.
REQ-036 Bench SHALL cover: REQ_SEL=3 -> ERR=1 for one cycle with S0/S1 unchanged; and RST asserted at MAKE cycle 3 -> S0=S1=0, DOUT_VLD=0 and REQ_RDY=1 the next cycle.
REQ-037 Bench SHALL cover: release with I0 connected -> S0=0 at t+1, REQ_RDY=1 at t+5, and DOUT_VLD never asserted.
